// File: rtl/mem_bus_arbiter.sv
// Shared single-port memory arbiter: NUM_MASTERS request ports, round-robin grant, registered handshake.
// Define MEM_BUS_FIXED_PRIO_EN to switch to fixed priority (lowest index wins).
module mem_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SEL_W       = DATA_W / 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*SEL_W-1:0]  m_sel,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          mem_ce,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [SEL_W-1:0]              mem_sel,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy,
  output logic [2:0]                    grant_id
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t                  state_r, state_s;
  logic [3:0]              wait_cnt_r, wait_cnt_s;
  logic [2:0]              last_grant_r, last_grant_s;
  logic [2:0]              grant_id_r, grant_id_s;
  logic [2:0]              winner_s;
  logic                    lat_we_r, lat_we_s;
  logic [NUM_MASTERS-1:0]  ack_r, ack_s;
  logic [DATA_W-1:0]       rdata_r, rdata_s;
  logic                    ce_r, ce_s, we_r, we_s;
  logic [ADDR_W-1:0]       addr_r, addr_s;
  logic [SEL_W-1:0]        sel_r, sel_s;
  logic [DATA_W-1:0]       wdata_r, wdata_s;
  logic                    win_we_s;
  logic [ADDR_W-1:0]       win_addr_s;
  logic [SEL_W-1:0]        win_sel_s;
  logic [DATA_W-1:0]       win_wdata_s;

  generate
    if (NUM_MASTERS == 1) begin : g_single
      assign winner_s = 3'd0;
    end else begin : g_arb
`ifdef MEM_BUS_FIXED_PRIO_EN
      logic [2:0] fp_win_s;
      // Lowest requesting index wins.
      always_comb begin
        fp_win_s = 3'd0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
          fp_win_s = m_req[i] ? 3'(i) : fp_win_s;
        end
      end
      assign winner_s = fp_win_s;
`else
      localparam int IDX_W = $clog2(NUM_MASTERS);
      logic [IDX_W-1:0] rr_idx_s;
      logic [2:0]       rr_win_s;
      logic             rr_found_s;
      logic             rr_hit_s;
      // Round-robin search starting just after the previous winner.
      always_comb begin
        rr_win_s   = 3'd0;
        rr_found_s = 1'b0;
        rr_idx_s   = {IDX_W{1'b0}};
        rr_hit_s   = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
          rr_idx_s   = IDX_W'((int'(last_grant_r) + k) % NUM_MASTERS);
          rr_hit_s   = !rr_found_s && m_req[rr_idx_s];
          rr_win_s   = rr_hit_s ? 3'(rr_idx_s) : rr_win_s;
          rr_found_s = rr_found_s || rr_hit_s;
        end
      end
      assign winner_s = rr_win_s;
`endif
    end
  endgenerate

  // Select the winning master's request fields.
  always_comb begin
    win_we_s    = 1'b0;
    win_addr_s  = {ADDR_W{1'b0}};
    win_sel_s   = {SEL_W{1'b0}};
    win_wdata_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_MASTERS; i++) begin
      win_we_s    = (winner_s == 3'(i)) ? m_we[i] : win_we_s;
      win_addr_s  = (winner_s == 3'(i)) ? m_addr[i*ADDR_W +: ADDR_W] : win_addr_s;
      win_sel_s   = (winner_s == 3'(i)) ? m_sel[i*SEL_W +: SEL_W] : win_sel_s;
      win_wdata_s = (winner_s == 3'(i)) ? m_wdata[i*DATA_W +: DATA_W] : win_wdata_s;
    end
  end

  // State and wait-counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      wait_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
    end
  end

  // Next-state logic; WAIT lasts exactly WAIT_CYCLES cycles.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    case (state_r)
      IDLE:  state_s = (|m_req) ? ISSUE : IDLE;
      ISSUE: begin
        if (WAIT_CYCLES > 0) begin
          state_s    = WAIT;
          wait_cnt_s = 4'(WAIT_CYCLES - 1);
        end else begin
          state_s = DONE;
        end
      end
      WAIT: begin
        if (wait_cnt_r == 4'd0) begin
          state_s = DONE;
        end else begin
          wait_cnt_s = wait_cnt_r - 4'd1;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs; ack and read capture happen on the edge into DONE.
  always_comb begin
    ack_s        = {NUM_MASTERS{1'b0}};
    rdata_s      = rdata_r;
    ce_s         = 1'b0;
    we_s         = we_r;
    addr_s       = addr_r;
    sel_s        = sel_r;
    wdata_s      = wdata_r;
    lat_we_s     = lat_we_r;
    last_grant_s = last_grant_r;
    grant_id_s   = grant_id_r;
    case (state_r)
      IDLE: begin
        if (|m_req) begin
          ce_s         = 1'b1;
          we_s         = win_we_s;
          addr_s       = win_addr_s;
          sel_s        = win_sel_s;
          wdata_s      = win_wdata_s;
          lat_we_s     = win_we_s;
          grant_id_s   = winner_s;
          last_grant_s = winner_s;
        end else begin
          ce_s = 1'b0;
          we_s = 1'b0;
        end
      end
      ISSUE, WAIT: begin
        we_s = 1'b0;
        if (state_s == DONE) begin
          ack_s   = NUM_MASTERS'(1'b1) << grant_id_r;
          rdata_s = lat_we_r ? rdata_r : mem_rdata;
        end else begin
          ack_s = {NUM_MASTERS{1'b0}};
        end
      end
      DONE:    we_s = 1'b0;
      default: we_s = 1'b0;
    endcase
  end

  // Output and latched-request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_r        <= {NUM_MASTERS{1'b0}};
      rdata_r      <= {DATA_W{1'b0}};
      ce_r         <= 1'b0;
      we_r         <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      sel_r        <= {SEL_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      lat_we_r     <= 1'b0;
      last_grant_r <= 3'(NUM_MASTERS - 1);
      grant_id_r   <= 3'd0;
    end else begin
      ack_r        <= ack_s;
      rdata_r      <= rdata_s;
      ce_r         <= ce_s;
      we_r         <= we_s;
      addr_r       <= addr_s;
      sel_r        <= sel_s;
      wdata_r      <= wdata_s;
      lat_we_r     <= lat_we_s;
      last_grant_r <= last_grant_s;
      grant_id_r   <= grant_id_s;
    end
  end

  assign m_ack     = ack_r;
  assign m_rdata   = rdata_r;
  assign mem_ce    = ce_r;
  assign mem_we    = we_r;
  assign mem_addr  = addr_r;
  assign mem_sel   = sel_r;
  assign mem_wdata = wdata_r;
  assign grant_id  = grant_id_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter (3 masters, 2 wait cycles, round-robin build).
module tb_mem_bus_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int W  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_req, m_we, m_ack;
  logic [N*AW-1:0] m_addr;
  logic [N*SW-1:0] m_sel;
  logic [N*DW-1:0] m_wdata;
  logic [DW-1:0]   m_rdata, mem_wdata, mem_rdata;
  logic            mem_ce, mem_we, busy, mem_load;
  logic [AW-1:0]   mem_addr;
  logic [SW-1:0]   mem_sel;
  logic [2:0]      grant_id;
  logic [DW-1:0]   mem [16];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [N-1:0] req;
    logic         we;
    logic [31:0]  base;
    logic [3:0]   sel;
    logic [31:0]  wdata;
    int           exp_win;
    logic [31:0]  exp_rdata;
  } vec_t;
  vec_t vt [8];

  // reference model state
  int           md_free, md_issue, md_ack, md_win, md_last;
  logic         md_we;
  logic [31:0]  md_addr, md_wdata, md_rd, md_rdata;
  logic [3:0]   md_sel;
  logic [2:0]   md_gid;
  logic [31:0]  md_mem [16];
  logic [N-1:0] drop_mask;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_sel(m_sel),
    .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata), .mem_ce(mem_ce), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_sel(mem_sel), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  function automatic logic [31:0] init_word(int i);
    return (i == 0) ? 32'hDEADBEEF : 32'h11111111 * 32'(i);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic int rr_pick(int last, logic [N-1:0] r);
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic int onehot_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v == (N'(1) << i)) return i;
    return -1;
  endfunction

  // behavioural memory behind the arbiter
  assign mem_rdata = mem[mem_addr[3:0]];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    end else if (mem_ce && mem_we) begin
      mem[mem_addr[3:0]] <= merge(mem[mem_addr[3:0]], mem_wdata, mem_sel);
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_master(int i, logic r, logic w, logic [31:0] a, logic [3:0] s, logic [31:0] d);
    m_req[i] = r;
    m_we[i]  = w;
    m_addr[i*AW +: AW]  = a;
    m_sel[i*SW +: SW]   = s;
    m_wdata[i*DW +: DW] = d;
  endtask

  task automatic model_reset();
    md_free = 0; md_issue = -1; md_ack = -1; md_win = 0; md_last = N - 1;
    md_we = 1'b0; md_addr = 32'h0; md_wdata = 32'h0; md_sel = 4'h0; md_gid = 3'd0;
    md_rdata = 32'h0; md_rd = 32'h0; drop_mask = '0;
    for (int i = 0; i < 16; i++) md_mem[i] = init_word(i);
  endtask

  task automatic model_check(int c);
    logic         e_ce;
    logic [N-1:0] e_ack;
    e_ce  = (c == md_issue);
    e_ack = (c == md_ack) ? (N'(1) << md_win) : '0;
    check("rnd_ack", 64'(m_ack), 64'(e_ack));
    check("rnd_ce", 64'(mem_ce), 64'(e_ce));
    check("rnd_we", 64'(mem_we), 64'(e_ce && md_we));
    check("rnd_busy", 64'(busy), 64'(md_issue >= 0 && c >= md_issue && c <= md_ack));
    check("rnd_gid", 64'(grant_id), 64'(md_gid));
    check("rnd_rdata", 64'(m_rdata), 64'(md_rdata));
    check("rnd_addr", 64'(mem_addr), 64'(md_addr));
    check("rnd_sel", 64'(mem_sel), 64'(md_sel));
    check("rnd_wdata", 64'(mem_wdata), 64'(md_wdata));
  endtask

  // one access = grant in cycle c, ISSUE c+1, ack c+2+W, arbiter free again at c+3+W
  task automatic model_step(int c);
    int w;
    if (c == md_ack) drop_mask[md_win] = 1'b1;
    if (c + 1 == md_ack && !md_we) md_rdata = md_rd;
    if (c >= md_free && m_req != '0) begin
      w = rr_pick(md_last, m_req);
      md_win = w; md_last = w; md_gid = 3'(w);
      md_issue = c + 1; md_ack = c + 2 + W; md_free = c + 3 + W;
      md_we = m_we[w]; md_addr = m_addr[w*AW +: AW];
      md_sel = m_sel[w*SW +: SW]; md_wdata = m_wdata[w*DW +: DW];
      if (md_we) md_mem[md_addr[3:0]] = merge(md_mem[md_addr[3:0]], md_wdata, md_sel);
      else md_rd = md_mem[md_addr[3:0]];
    end
  endtask

  initial begin
    int lat, ce_k, n, cnt0, cnt1;
    logic ce_we, ack0_seen;
    logic [3:0] ce_sel;
    logic [31:0] ce_addr, rd;
    logic [N-1:0] ackv;
    int ord [6];
    int tm [6];

    vt[0] = '{3'b001, 1'b0, 32'h100, 4'hF, 32'h0,         0, 32'hDEADBEEF};
    vt[1] = '{3'b011, 1'b0, 32'h2,   4'hF, 32'h0,         1, 32'h33333333};
    vt[2] = '{3'b011, 1'b1, 32'h4,   4'h3, 32'h12345678,  0, 32'h33333333};
    vt[3] = '{3'b110, 1'b0, 32'h3,   4'hF, 32'h0,         1, 32'h44445678};
    vt[4] = '{3'b111, 1'b0, 32'h0,   4'hF, 32'h0,         2, 32'h22222222};
    vt[5] = '{3'b100, 1'b1, 32'h5,   4'h8, 32'hAB000000,  2, 32'h22222222};
    vt[6] = '{3'b101, 1'b0, 32'h5,   4'hF, 32'h0,         0, 32'h55555555};
    vt[7] = '{3'b100, 1'b0, 32'h5,   4'hF, 32'h0,         2, 32'hAB777777};

    // reset with random inputs
    rst = 1'b0; mem_load = 1'b1;
    m_req = N'($urandom); m_we = N'($urandom);
    m_addr = {$urandom, $urandom, $urandom}; m_sel = 12'($urandom);
    m_wdata = {$urandom, $urandom, $urandom};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 64'(m_ack), 64'd0);
    check("rst_rdata", 64'(m_rdata), 64'd0);
    check("rst_mem", 64'({mem_ce, mem_we, mem_sel}), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_busy_gid", 64'({busy, grant_id}), 64'd0);
    m_req = '0; rst = 1'b1; mem_load = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_ce", 64'(mem_ce), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
    end

    // table of isolated transactions
    for (int v = 0; v < 8; v++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) set_master(i, vt[v].req[i], vt[v].we, vt[v].base + 32'(i), vt[v].sel, vt[v].wdata);
      lat = -1; ce_k = -1; ce_we = 1'b0; ce_sel = 4'h0; ce_addr = 32'h0; ackv = '0; rd = 32'h0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (mem_ce && ce_k < 0) begin ce_k = k; ce_we = mem_we; ce_sel = mem_sel; ce_addr = mem_addr; end
        if (m_ack != '0) begin lat = k; ackv = m_ack; rd = m_rdata; break; end
      end
      m_req = '0;
      check("vec_ack", 64'(ackv), 64'(N'(1) << vt[v].exp_win));
      check("vec_latency", 64'(lat), 64'(2 + W));
      check("vec_ce_cycle", 64'(ce_k), 64'd1);
      check("vec_mem_we", 64'(ce_we), 64'(vt[v].we));
      check("vec_mem_sel", 64'(ce_sel), 64'(vt[v].sel));
      check("vec_mem_addr", 64'(ce_addr), 64'(vt[v].base + 32'(vt[v].exp_win)));
      check("vec_rdata", 64'(rd), 64'(vt[v].exp_rdata));
    end

    // reset during WAIT abandons the access; master 0 wins next
    @(posedge clk); #1;
    set_master(0, 1'b0, 1'b0, 32'h0, 4'hF, 32'h0);
    set_master(1, 1'b1, 1'b0, 32'h1, 4'hF, 32'h0);
    repeat (3) @(negedge clk);
    check("midwait_busy", 64'(busy), 64'd1);
    rst = 1'b0; #1;
    check("midwait_rst", 64'({busy, mem_ce, m_ack, grant_id}), 64'd0);
    m_req = 3'b011;
    @(posedge clk);
    @(negedge clk);
    check("midwait_noack", 64'(m_ack), 64'd0);
    rst = 1'b1;
    ackv = '0; rd = 32'h0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_ack != '0) begin ackv = m_ack; rd = m_rdata; break; end
    end
    m_req = '0;
    check("midwait_next_ack", 64'(ackv), 64'b001);
    check("midwait_rdata", 64'(rd), 64'hDEADBEEF);

    // request withdrawn before it is granted is never served
    cnt0 = 0; cnt1 = 0; ack0_seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      m_req[0] = !ack0_seen;
      m_req[1] = (k == 2);
      @(negedge clk);
      if (m_ack[0]) begin ack0_seen = 1'b1; cnt0++; end
      if (m_ack[1]) cnt1++;
    end
    check("withdraw_ack0", 64'(cnt0), 64'd1);
    check("withdraw_ack1", 64'(cnt1), 64'd0);

    // contention: all masters held -> 0,1,2,0,1,2 with 3+W spacing
    @(negedge clk); rst = 1'b0; m_req = '0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    m_req = 3'b111;
    n = 0;
    for (int k = 0; k < 80 && n < 6; k++) begin
      @(negedge clk);
      if (m_ack != '0) begin ord[n] = onehot_idx(m_ack); tm[n] = k; n++; end
    end
    m_req = '0;
    check("rr_count", 64'(n), 64'd6);
    for (int j = 0; j < n; j++) check("rr_order", 64'(ord[j]), 64'(j % N));
    for (int j = 1; j < n; j++) check("rr_spacing", 64'(tm[j] - tm[j-1]), 64'(3 + W));

    // randomized traffic against the transaction-level model
    @(negedge clk); rst = 1'b0; mem_load = 1'b1; m_req = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk); rst = 1'b1; mem_load = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (drop_mask[i]) begin
          m_req[i] = 1'b0;
        end else if (!m_req[i] && $urandom_range(0, 3) == 0) begin
          set_master(i, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)),
                     4'($urandom_range(1, 15)), $urandom);
        end else if (m_req[i] && $urandom_range(0, 31) == 0) begin
          m_req[i] = 1'b0;
        end
      end
      drop_mask = '0;
      @(negedge clk);
      model_check(t);
      model_step(t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
